// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// ----------------
// Stall/flush generator for the five-stage pipeline. It drives the enable
// (stall) and clear (flush) controls of the F/D/E/M/W stage registers.
// It also tracks one outstanding sram-like instruction fetch and one data
// access, runs the divider busy counter, and sequences exception flushes.
// Exception flushes can be deferred behind a data access, and an instruction
// response that belongs to a flushed fetch is discarded.
//
// Handshake: a bus request is accepted in the cycle req & addr_ok. Its
// response is the single-cycle data_ok pulse that follows. Only one
// transaction per port may be in flight, so a new fetch may only be
// presented while inst_req_allow is 1.
//
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   inst_req/addr_ok/data_ok    instruction port handshake
//   data_req/addr_ok/data_ok    data port handshake (M stage)
//   div_start                   E-stage divide issues
//   load_use                    load-use hazard from the detector
//   exc_flush                   exception/eret commit from the M stage
//   inst_req_allow              1 when no fetch is outstanding
//   inst_resp_valid             inst_data_ok with stale responses removed
//   stallF..stallW              hold the stage register
//   flushF..flushW              clear the stage register
//   div_busy                    divider counter nonzero
module pipe_hazard_ctrl #(
    parameter int DIV_CYCLES = 34,
    parameter int CNT_W      = 6
) (
    input  logic clk,
    input  logic resetn,
    input  logic inst_req,
    input  logic inst_addr_ok,
    input  logic inst_data_ok,
    input  logic data_req,
    input  logic data_addr_ok,
    input  logic data_data_ok,
    input  logic div_start,
    input  logic load_use,
    input  logic exc_flush,
    output logic inst_req_allow,
    output logic inst_resp_valid,
    output logic stallF,
    output logic stallD,
    output logic stallE,
    output logic stallM,
    output logic stallW,
    output logic flushF,
    output logic flushD,
    output logic flushE,
    output logic flushM,
    output logic flushW,
    output logic div_busy
);

    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             inst_pend_q, inst_pend_d;
    logic             data_pend_q, data_pend_d;
    logic             inst_discard_q, inst_discard_d;
    logic             exc_hold_q, exc_hold_d;
    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;

    logic ds, vs, lu, is, ex, busy;

    // Raw stall sources
    assign busy = (div_cnt_q != '0);
    assign ds   = data_pend_q & ~data_data_ok;
    // The divider releases the pipe one cycle early, while the counter is at 1.
    assign vs   = busy & (div_cnt_q != CNT_ONE);
    assign lu   = load_use;
    assign is   = inst_pend_q & ~inst_data_ok;
    // An exception cannot flush M while its data access is still outstanding.
    assign ex   = (exc_flush | exc_hold_q) & ~ds;

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inst_pend_q    <= 1'b0;
            data_pend_q    <= 1'b0;
            inst_discard_q <= 1'b0;
            exc_hold_q     <= 1'b0;
            div_cnt_q      <= '0;
        end else begin
            inst_pend_q    <= inst_pend_d;
            data_pend_q    <= data_pend_d;
            inst_discard_q <= inst_discard_d;
            exc_hold_q     <= exc_hold_d;
            div_cnt_q      <= div_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        inst_pend_d    = inst_pend_q;
        data_pend_d    = data_pend_q;
        inst_discard_d = inst_discard_q;
        exc_hold_d     = exc_hold_q;
        div_cnt_d      = div_cnt_q;

        // A new acceptance wins over a same-cycle response: the pipe stays busy.
        if (inst_req & inst_addr_ok)  inst_pend_d = 1'b1;
        else if (inst_data_ok)        inst_pend_d = 1'b0;

        if (data_req & data_addr_ok)  data_pend_d = 1'b1;
        else if (data_data_ok)        data_pend_d = 1'b0;

        if (!busy) begin
            if (div_start) div_cnt_d = DIV_LOAD;
        end else begin
            div_cnt_d = div_cnt_q - CNT_ONE;
        end

        if (ex)                    exc_hold_d = 1'b0;
        else if (ds & exc_flush)   exc_hold_d = 1'b1;

        // The fetch in flight at flush time returns a stale instruction.
        if (ex & is)               inst_discard_d = 1'b1;
        else if (inst_data_ok)     inst_discard_d = 1'b0;
    end

    // Output logic
    always_comb begin
        inst_req_allow  = 1'b1;
        inst_resp_valid = 1'b0;
        div_busy        = 1'b0;
        stallF = 1'b0; stallD = 1'b0; stallE = 1'b0; stallM = 1'b0; stallW = 1'b0;
        flushF = 1'b0; flushD = 1'b0; flushE = 1'b0; flushM = 1'b0; flushW = 1'b0;

        // Held in reset, outputs show the idle pattern whatever the inputs do.
        if (resetn) begin
            inst_req_allow  = ~inst_pend_q | inst_data_ok;
            inst_resp_valid = inst_data_ok & ~inst_discard_q;
            div_busy        = busy;

            if (ex) begin
                flushF = 1'b1; flushD = 1'b1; flushE = 1'b1; flushM = 1'b1;
            end else if (ds) begin
                stallF = 1'b1; stallD = 1'b1; stallE = 1'b1; stallM = 1'b1;
                flushW = 1'b1;
            end else if (vs) begin
                stallF = 1'b1; stallD = 1'b1; stallE = 1'b1;
                flushM = 1'b1;
            end else if (lu) begin
                stallF = 1'b1; stallD = 1'b1;
                flushE = 1'b1;
            end else if (is) begin
                stallF = 1'b1;
                flushD = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed and randomised stimulus for pipe_hazard_ctrl. Each cycle's
// expected output vector is pushed when the inputs are driven and popped
// and compared at the following falling edge.
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic inst_req = 1'b0, inst_addr_ok = 1'b0, inst_data_ok = 1'b0;
    logic data_req = 1'b0, data_addr_ok = 1'b0, data_data_ok = 1'b0;
    logic div_start = 1'b0, load_use = 1'b0, exc_flush = 1'b0;
    logic inst_req_allow, inst_resp_valid, div_busy;
    logic stallF, stallD, stallE, stallM, stallW;
    logic flushF, flushD, flushE, flushM, flushW;

    pipe_hazard_ctrl #(.DIV_CYCLES(34), .CNT_W(6)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .div_start(div_start), .load_use(load_use), .exc_flush(exc_flush),
        .inst_req_allow(inst_req_allow), .inst_resp_valid(inst_resp_valid),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM), .stallW(stallW),
        .flushF(flushF), .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
        .div_busy(div_busy)
    );

    // clock / reset
    always #5 clk = ~clk;

    // Input bits
    localparam logic [8:0] I_REQ = 9'h100, I_AOK = 9'h080, I_DOK = 9'h040;
    localparam logic [8:0] D_REQ = 9'h020, D_AOK = 9'h010, D_DOK = 9'h008;
    localparam logic [8:0] DIV   = 9'h004, LU    = 9'h002, EXC   = 9'h001;
    localparam logic [8:0] NONE  = 9'h000;

    // Output vector {allow, resp_valid, busy, stallF..W, flushF..W}
    localparam logic [12:0] ALLOW = 13'h1000, RV = 13'h0800, BUSY = 13'h0400;
    localparam logic [12:0] SF = 13'h0200, SD = 13'h0100, SE = 13'h0080, SM = 13'h0040;
    localparam logic [12:0] FF = 13'h0010, FD = 13'h0008, FE = 13'h0004, FM = 13'h0002, FW = 13'h0001;

    localparam logic [12:0] P_DS   = SF | SD | SE | SM | FW;
    localparam logic [12:0] P_DIV  = SF | SD | SE | FM;
    localparam logic [12:0] P_LU   = SF | SD | FE;
    localparam logic [12:0] P_IS   = SF | FD;
    localparam logic [12:0] P_EXC  = FF | FD | FE | FM;

    logic [12:0] outs;
    assign outs = {inst_req_allow, inst_resp_valid, div_busy,
                   stallF, stallD, stallE, stallM, stallW,
                   flushF, flushD, flushE, flushM, flushW};

    // scoreboard
    logic [12:0] exp_q[$];
    int n_total = 0;
    int n_bad   = 0;

    task automatic check_val(input string tag, input logic [12:0] got, input logic [12:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%013b exp=%013b", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [8:0] iv);
        {inst_req, inst_addr_ok, inst_data_ok,
         data_req, data_addr_ok, data_data_ok,
         div_start, load_use, exc_flush} = iv;
    endtask

    task automatic sample(input string tag);
        logic [12:0] e;
        if (exp_q.size() == 0) begin
            n_total++;
            n_bad++;
            $display("FAIL %s: got=%013b exp=<empty queue>", tag, outs);
        end else begin
            e = exp_q.pop_front();
            check_val(tag, outs, e);
        end
    endtask

    // One clock cycle: drive after the rising edge, compare at the falling edge.
    task automatic cyc(input logic [8:0] iv, input logic [12:0] exp, input string tag);
        @(posedge clk);
        #1;
        drive(iv);
        exp_q.push_back(exp);
        @(negedge clk);
        sample(tag);
    endtask

    initial begin
        // Reset state
        #2;
        exp_q.push_back(ALLOW);
        sample("reset");
        #10 resetn = 1'b1;

        // Fetch: accepted cycle 1, response cycle 4
        cyc(I_REQ | I_AOK, ALLOW,      "fetch_c1");
        cyc(NONE,          P_IS,       "fetch_c2");
        cyc(NONE,          P_IS,       "fetch_c3");
        cyc(I_DOK,         ALLOW | RV, "fetch_c4");
        cyc(NONE,          ALLOW,      "fetch_idle");

        // Back-to-back fetch: new acceptance alongside a response keeps pend set
        cyc(I_REQ | I_AOK,         ALLOW,      "b2b_a");
        cyc(I_REQ | I_AOK | I_DOK, ALLOW | RV, "b2b_overlap");
        cyc(NONE,                  P_IS,       "b2b_pend");
        cyc(I_DOK,                 ALLOW | RV, "b2b_resp");

        // Divide: 33 stall cycles, busy for 34; second start, load_use and
        // an exception during the divide
        cyc(DIV, ALLOW, "div_start");
        for (int k = 1; k <= 33; k++) begin
            if (k == 10)      cyc(DIV,  ALLOW | BUSY | P_DIV, "div_restart_ignored");
            else if (k == 5)  cyc(LU,   ALLOW | BUSY | P_DIV, "div_over_lu");
            else if (k == 20) cyc(EXC,  ALLOW | BUSY | P_EXC, "div_exc");
            else              cyc(NONE, ALLOW | BUSY | P_DIV, "div_stall");
        end
        cyc(NONE, ALLOW | BUSY, "div_cnt1");
        cyc(NONE, ALLOW,        "div_done");

        // Load-use, single cycle
        cyc(LU,   ALLOW | P_LU, "lu");
        cyc(NONE, ALLOW,        "lu_next");

        // Exception deferred behind an outstanding data access
        cyc(D_REQ | D_AOK, ALLOW,         "dexc_req");
        cyc(EXC,           P_DS | ALLOW,  "dexc_w1");
        cyc(NONE,          P_DS | ALLOW,  "dexc_w2");
        cyc(NONE,          P_DS | ALLOW,  "dexc_w3");
        cyc(D_DOK,         P_EXC | ALLOW, "dexc_flush");
        cyc(NONE,          ALLOW,         "dexc_after");

        // Exception with a fetch outstanding: the late response is discarded
        cyc(I_REQ | I_AOK, ALLOW,      "iexc_req");
        cyc(EXC,           P_EXC,      "iexc_flush");
        cyc(NONE,          P_IS,       "iexc_wait");
        cyc(I_DOK,         ALLOW,      "iexc_discard");
        cyc(NONE,          ALLOW,      "iexc_pend_clr");
        cyc(I_REQ | I_AOK, ALLOW,      "iexc_refetch");
        cyc(I_DOK,         ALLOW | RV, "iexc_valid");

        // Random load_use with nothing else active
        for (int k = 0; k < 20; k++) begin
            if ($urandom_range(1, 0) == 1) cyc(LU,   ALLOW | P_LU, "rand_lu");
            else                           cyc(NONE, ALLOW,        "rand_idle");
        end

        // Asynchronous reset mid-divide with both ports pending
        cyc(I_REQ | I_AOK | D_REQ | D_AOK | DIV, ALLOW,              "mix_start");
        cyc(NONE,                                BUSY | P_DS,        "mix_busy");
        @(posedge clk);
        #1;
        drive(NONE);
        #2;
        resetn = 1'b0;
        #1;
        exp_q.push_back(ALLOW);
        sample("async_reset");
        @(negedge clk);
        resetn = 1'b1;
        cyc(NONE, ALLOW, "post_reset");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
